if_stage: RTL and testbench

//   Instruction-fetch stage of the 5-stage RV pipeline. Owns the PC register and selects the next PC
//   (sequential, branch redirect or hold). Drives the instruction-memory address and captures the

---
 rtl/if_stage.sv | 130 +++++++++++++
 tb/tb_if_stage.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// ---------------------------------------------------------------------------
// if_stage -- instruction-fetch stage of the 5-stage RV pipeline.
//
// Owns the PC, chooses the next PC (sequential, branch redirect or hold),
// presents the PC to instruction memory and captures the returned word into
// the IF/ID pipeline register. Stall holds PC and IF/ID. A taken branch
// redirects the PC and flushes IF/ID. Fetching the exit opcode freezes fetch
// in the HALTED state until an older branch redirects it.
//
// Ports
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   stall          hold PC, IF/ID and fetch_count this cycle
//   branch_taken   redirect to branch_target and flush IF/ID
//   branch_target  redirect PC (low two bits are forced to zero)
//   imem_addr      instruction-memory address (= pc, combinational)
//   imem_rdata     instruction word for imem_addr, same cycle
//   if_id_pc       PC of the instruction held in IF/ID
//   if_id_instr    instruction held in IF/ID
//   if_id_valid    IF/ID holds a real (non-bubble) instruction
//   halted         registered, high while fetch is frozen
//   fetch_count    saturating count of instructions accepted into IF/ID
// ---------------------------------------------------------------------------
module if_stage #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013,
  parameter logic [6:0]  HALT_OPCODE = 7'b1111111,
  parameter int          CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [31:0]      branch_target,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  output logic [31:0]      if_id_pc,
  output logic [31:0]      if_id_instr,
  output logic             if_id_valid,
  output logic             halted,
  output logic [CNT_W-1:0] fetch_count
);

  typedef enum logic {RUN, HALTED} state_t;

  state_t           state;
  logic [31:0]      pc_p0;
  logic [31:0]      pc_p1;
  logic [31:0]      instr_p1;
  logic             vld_p1;
  logic             halted_q;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0]      target_aligned;
  logic             is_exit;

  // Count of accepted fetches sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    if (&c) return c;
    return c + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  assign target_aligned = {branch_target[31:2], 2'b00};
  assign is_exit        = (imem_rdata[6:0] == HALT_OPCODE);

  // ---- IF: PC drives instruction memory directly ----
  assign imem_addr = pc_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= RUN;
      halted_q <= 1'b0;
      pc_p0    <= RESET_PC;
      pc_p1    <= 32'h0000_0000;
      instr_p1 <= NOP_INSTR;
      vld_p1   <= 1'b0;
      cnt_q    <= '0;
    end else begin
      case (state)
        RUN: begin
          if (branch_taken) begin
            // Flush beats stall: the fetched word is on the wrong path.
            pc_p0    <= target_aligned;
            pc_p1    <= 32'h0000_0000;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end else if (!stall) begin
            pc_p1    <= pc_p0;
            instr_p1 <= imem_rdata;
            vld_p1   <= 1'b1;
            cnt_q    <= sat_inc(cnt_q);
            if (is_exit) begin
              // Exit word is delivered downstream; PC parks on it.
              state    <= HALTED;
              halted_q <= 1'b1;
            end else begin
              pc_p0 <= pc_p0 + 32'd4;
            end
          end
        end
        HALTED: begin
          if (branch_taken) begin
            // An older branch still in flight squashes the exit.
            state    <= RUN;
            halted_q <= 1'b0;
            pc_p0    <= target_aligned;
            pc_p1    <= 32'h0000_0000;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end else if (!stall) begin
            pc_p1    <= 32'h0000_0000;
            instr_p1 <= NOP_INSTR;
            vld_p1   <= 1'b0;
          end
        end
        default: begin
          state    <= RUN;
          halted_q <= 1'b0;
        end
      endcase
    end
  end

  // ---- IF/ID register outputs ----
  assign if_id_pc    = pc_p1;
  assign if_id_instr = instr_p1;
  assign if_id_valid = vld_p1;
  assign halted      = halted_q;
  assign fetch_count = cnt_q;

endmodule

// File: tb/tb_if_stage.sv
// ---------------------------------------------------------------------------
// tb_if_stage -- self-checking bench for if_stage.
// A reference model of the fetch rules runs alongside the DUT and is compared
// on every falling edge; directed literal expectations pin the model.
// The counter is built narrow so saturation is reachable in a short run.
// ---------------------------------------------------------------------------
module tb_if_stage;
  localparam int CNT_W = 4;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic             clk;
  logic             rst_n;
  logic             stall;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic [31:0]      imem_addr;
  logic [31:0]      imem_rdata;
  logic [31:0]      if_id_pc;
  logic [31:0]      if_id_instr;
  logic             if_id_valid;
  logic             halted;
  logic [CNT_W-1:0] fetch_count;

  logic [31:0] halt_addr;
  int errors = 0;
  int checks = 0;
  bit chk_en = 0;

  // model state
  logic [31:0]      m_pc, m_ifpc, m_instr;
  logic             m_valid, m_halted;
  logic [CNT_W-1:0] m_cnt;

  if_stage #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .if_id_pc(if_id_pc), .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .halted(halted), .fetch_count(fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instruction memory: word = 0x1000_0033 | addr<<8, exit word at halt_addr.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] h);
    if (a == h) return 32'h0000_007F;
    return 32'h1000_0033 | (a << 8);
  endfunction

  assign imem_rdata = (imem_addr == halt_addr) ? 32'h0000_007F
                                               : (32'h1000_0033 | (imem_addr << 8));

  // Reference model: one step per rising edge, reset asynchronously.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pc = 32'h0; m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      m_halted = 1'b0; m_cnt = '0;
    end else if (branch_taken) begin
      m_pc = branch_target & 32'hFFFF_FFFC;
      m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0; m_halted = 1'b0;
    end else if (!stall) begin
      if (m_halted) begin
        m_ifpc = 32'h0; m_instr = NOP; m_valid = 1'b0;
      end else begin
        m_ifpc  = m_pc;
        m_instr = mem_word(m_pc, halt_addr);
        m_valid = 1'b1;
        if (m_cnt != {CNT_W{1'b1}}) m_cnt = m_cnt + 1'b1;
        if (m_instr[6:0] == 7'h7F) m_halted = 1'b1;
        else m_pc = m_pc + 32'd4;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m.imem_addr", imem_addr, m_pc);
      chk("m.if_id_pc", if_id_pc, m_ifpc);
      chk("m.if_id_instr", if_id_instr, m_instr);
      chk("m.if_id_valid", {31'b0, if_id_valid}, {31'b0, m_valid});
      chk("m.halted", {31'b0, halted}, {31'b0, m_halted});
      chk("m.fetch_count", {{(32-CNT_W){1'b0}}, fetch_count}, {{(32-CNT_W){1'b0}}, m_cnt});
    end
  end

  task automatic step(input logic s, input logic b, input logic [31:0] t);
    stall = s; branch_taken = b; branch_target = t;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_ifid(input string n, input logic [31:0] p, input logic [31:0] i,
                          input logic v);
    chk({n, ".pc"}, if_id_pc, p);
    chk({n, ".instr"}, if_id_instr, i);
    chk({n, ".valid"}, {31'b0, if_id_valid}, {31'b0, v});
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_target = 32'h0;
    halt_addr = 32'hFFFF_FFF0;
    @(negedge clk);
    @(negedge clk);
    chk_ifid("rst", 32'h0, NOP, 1'b0);
    chk("rst.addr", imem_addr, 32'h0);
    chk("rst.halted", {31'b0, halted}, 32'h0);
    chk("rst.cnt", {28'b0, fetch_count}, 32'h0);
    rst_n = 1'b1;
    chk_en = 1'b1;

    // sequential fetch
    step(0, 0, 0); chk_ifid("seq1", 32'h0, 32'h1000_0033, 1'b1);
    step(0, 0, 0); chk_ifid("seq2", 32'h4, 32'h1000_0433, 1'b1);
    step(0, 0, 0); chk_ifid("seq3", 32'h8, 32'h1000_0833, 1'b1);
    chk("seq3.cnt", {28'b0, fetch_count}, 32'd3);
    chk("seq3.addr", imem_addr, 32'hC);

    // stall holds everything
    step(1, 0, 0); step(1, 0, 0);
    chk_ifid("stall", 32'h8, 32'h1000_0833, 1'b1);
    chk("stall.addr", imem_addr, 32'hC);
    chk("stall.cnt", {28'b0, fetch_count}, 32'd3);
    step(0, 0, 0); chk_ifid("resume", 32'hC, 32'h1000_0C33, 1'b1);

    // branch wins over stall, target aligned down
    step(1, 1, 32'h42);
    chk("br.addr", imem_addr, 32'h40);
    chk_ifid("br", 32'h0, NOP, 1'b0);
    chk("br.cnt", {28'b0, fetch_count}, 32'd4);

    // exit opcode
    halt_addr = 32'h1C;
    step(0, 1, 32'h1C);
    step(0, 0, 0);
    chk_ifid("exit", 32'h1C, 32'h7F, 1'b1);
    chk("exit.halted", {31'b0, halted}, 32'h1);
    chk("exit.addr", imem_addr, 32'h1C);
    chk("exit.cnt", {28'b0, fetch_count}, 32'd5);
    step(1, 0, 0); chk_ifid("hstall", 32'h1C, 32'h7F, 1'b1);
    step(0, 0, 0); chk_ifid("hbub", 32'h0, NOP, 1'b0);
    step(0, 0, 0);
    chk("hbub.addr", imem_addr, 32'h1C);
    chk("hbub.cnt", {28'b0, fetch_count}, 32'd5);
    step(0, 1, 32'h10);
    chk("unhalt", {31'b0, halted}, 32'h0);
    chk("unhalt.addr", imem_addr, 32'h10);
    step(0, 0, 0); chk_ifid("after", 32'h10, 32'h1000_1033, 1'b1);
    halt_addr = 32'hFFFF_FFF0;

    // PC wrap
    step(0, 1, 32'hFFFF_FFFC);
    step(0, 0, 0);
    chk("wrap.addr", imem_addr, 32'h0);
    chk_ifid("wrap", 32'hFFFF_FFFC, 32'hFFFF_FC33, 1'b1);

    // async reset mid-run with stall and branch high
    step(0, 0, 0);
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'h80;
    #2 rst_n = 1'b0;
    #1;
    chk_ifid("arst", 32'h0, NOP, 1'b0);
    chk("arst.addr", imem_addr, 32'h0);
    chk("arst.cnt", {28'b0, fetch_count}, 32'h0);
    chk("arst.halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0); chk_ifid("post", 32'h0, 32'h1000_0033, 1'b1);

    // counter saturation
    for (int i = 0; i < 18; i++) step(0, 0, 0);
    chk("sat.cnt", {28'b0, fetch_count}, 32'd15);
    chk("sat.addr", imem_addr, 32'h4C);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end
endmodule
